control_seq: RTL and testbench
==============================

# control_seq

Sequenced control unit for the nic8 datapath, replacing the purely combinational decoder. It holds the instruction register, runs a fetch/execute state machine with a configurable number of memory wait states, and owns the carry and shift flag registers. It drives one-hot, active-high register-load and bus-source strobes to the existing datapath, and applies jump conditions against the registered flags and an internal A-zero test.

## Interface
- `WIDTH`, default 8: width of the A operand used for the zero test.
- `MEM_WAIT`, default 0: extra cycles (0..15) inserted before each memory-touching strobe cycle.
- `clk` in 1: single clock, rising edge.
- `resetBar` in 1: reset, synchronous and active-low.
- `irIn` in 8: instruction byte from ROM at PC.
- `a` in WIDTH: current A register value.
- `aluCarry` in 1: ALU carry out.
- `aluShift` in 1: shifter bit out.
- `run` in 1: when low, the unit holds in FETCH without strobing (single-step/halt).
- `ir` out 8: registered instruction, split as {bit7, dest[2:0], bit3, source[2:0]}.
- `loadIr` out 1: latch strobe for `irIn`.
- `incPc` out 1: PC increment strobe.
- `load` out 8: one-hot destination strobe. Bit 2 is A, 3 is B, 4 is X, 5 is RAM store, 6 is Q, 7 is PC (jump taken). Bits 0 and 1 are never set.
- `assertSrc` out 8: one-hot bus source. 0 is zero, 1 is ROM, 2 is A, 3 is B, 4 is X, 5 is RAM, 6 is ALU (E), 7 is shifter (S).
- `doSubtract`, `doCarryIn`, `doShiftIn` out 1: equal to ir bit3, bit7 and bit3 respectively.
- `flagCarry`, `flagShift` out 1: registered flags.
- `busy` out 1: high in any state except idle FETCH with `run` low.

## Operation
- States are FETCH, FETCH_WAIT, EXEC and EXEC_WAIT. A 4-bit wait counter `cnt` supports them.
- **FETCH**
  - If `run` is low, stay in FETCH.
  - If `run` is high and MEM_WAIT=0, this is the strobe cycle: `loadIr`=1, `incPc`=1, `ir`<=`irIn`, and the next state is EXEC.
  - If `run` is high and MEM_WAIT>0, go to FETCH_WAIT with `cnt`=0.
- **FETCH_WAIT**
  - `cnt` increments each cycle.
  - The cycle with `cnt`==MEM_WAIT-1 is the strobe cycle, with the same actions as the FETCH strobe cycle.
- **EXEC**
  - `assertSrc` = onehot(source), held for every cycle spent in EXEC and EXEC_WAIT.
  - An instruction is a memory op if source==1, source==5 or dest==5.
  - A memory op with MEM_WAIT>0 goes to EXEC_WAIT and strobes on its final cycle, as in FETCH_WAIT.
  - Otherwise EXEC is the strobe cycle.
  - After the strobe cycle the next state is FETCH.
- **Strobe cycle**
  - `load[d]`=1 for dest d in 2..6.
  - `load[7]`=1 only if the jump condition holds.
  - `incPc`=1 if source==1 (immediate consumed) and the jump is not taken.
  - If source==6, `flagCarry`<=`aluCarry`. If source==7, `flagShift`<=`aluShift`.
- **Jump condition**, selected by {bit7, bit3}:
  - 00: unconditional.
  - 01: `a`==0, over all WIDTH bits.
  - 10: `flagCarry`.
  - 11: `flagShift`.
  - The flag values used are those registered before the strobe edge.
- Dest 0 or 1 is a no-op load. The source is still asserted and the flags are still updated.

## Timing
- All strobes are combinational from the registered state, `ir` and `cnt`. They are valid for the whole cycle and are consumed by the datapath at the rising edge ending that cycle.
- Instruction length:
  - Non-memory op: 2 cycles.
  - Memory op: 2 + 2·MEM_WAIT cycles.
  - Non-memory op when MEM_WAIT>0: 2 + MEM_WAIT cycles (the fetch wait still applies).
- Reset (`resetBar` low at an edge):
  - Next state is FETCH, `cnt`=0, `ir`=8'h00, `flagCarry`=`flagShift`=0.
  - While `resetBar` is low, all strobes, `loadIr`, `incPc` and `busy` are forced to 0.
  - Reset mid-WAIT abandons the instruction with no strobe.
- `run` is sampled only in FETCH. Dropping it mid-instruction completes that instruction.
- `cnt` never exceeds MEM_WAIT-1. It returns to 0 on every state change.

## Structure
- Package `control_pkg` holds:
  - The state enum.
  - Source codes SRC_ZERO..SRC_S, values 0..7.
  - Destination codes DST_A=2, DST_B=3, DST_X=4, DST_RAM=5, DST_Q=6, DST_PC=7.
  - Condition codes COND_UNCOND/ZERO/CARRY/SHIFT.
  - The `is_mem_op` function.
- One sub-module, `wait_counter` (parameter MEM_WAIT). Inputs are start and enable; output is `done`, a one-cycle pulse on the final wait cycle. It is instantiated once and shared between FETCH_WAIT and EXEC_WAIT.

## Test plan
- **Reset:** hold `resetBar`=0 for 3 cycles with `run`=1 → all strobes 0, `ir`=00, flags 0. On release, `loadIr` pulses in the first cycle.
- **Immediate load A** (ir=8'h21, MEM_WAIT=0): `assertSrc`=8'h02 and `load`=8'h04 in the EXEC cycle; `incPc` pulses in both FETCH and EXEC; 2 cycles total.
- **Conditional jump on zero** (ir=8'h79, source ROM, bit3=1):
  - With `a`=0: `load[7]`=1 and no EXEC `incPc`.
  - With `a`=8'h01: `load[7]`=0 and `incPc`=1.
- **Flags** (ir=8'h36, ALU to B): with `aluCarry`=1, `flagCarry`=1 after the EXEC edge. A following jump with ir=8'hF1 takes the jump.
- **Waits** (MEM_WAIT=3, RAM store ir=8'h52): 8 cycles total. `load[5]` is high for exactly 1 cycle, the last one. `assertSrc`=8'h04 is held for all 4 EXEC cycles.
- **Halt and mid-wait reset:**
  - `run`=0 → the unit stays in FETCH with `busy`=0.
  - Reset asserted during EXEC_WAIT → no `load` pulse; the unit restarts in FETCH.

Source files
------------

// File: rtl/control_seq_pkg.sv
// Shared types and encodings for the nic8 sequenced control unit.
package control_pkg;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    FETCH_WAIT = 2'd1,
    EXEC       = 2'd2,
    EXEC_WAIT  = 2'd3
  } state_t;

  localparam logic [2:0] SRC_ZERO = 3'd0;
  localparam logic [2:0] SRC_ROM  = 3'd1;
  localparam logic [2:0] SRC_A    = 3'd2;
  localparam logic [2:0] SRC_B    = 3'd3;
  localparam logic [2:0] SRC_X    = 3'd4;
  localparam logic [2:0] SRC_RAM  = 3'd5;
  localparam logic [2:0] SRC_E    = 3'd6;
  localparam logic [2:0] SRC_S    = 3'd7;

  localparam logic [2:0] DST_A   = 3'd2;
  localparam logic [2:0] DST_B   = 3'd3;
  localparam logic [2:0] DST_X   = 3'd4;
  localparam logic [2:0] DST_RAM = 3'd5;
  localparam logic [2:0] DST_Q   = 3'd6;
  localparam logic [2:0] DST_PC  = 3'd7;

  localparam logic [1:0] COND_UNCOND = 2'b00;
  localparam logic [1:0] COND_ZERO   = 2'b01;
  localparam logic [1:0] COND_CARRY  = 2'b10;
  localparam logic [1:0] COND_SHIFT  = 2'b11;

  // An instruction touches memory when it reads ROM/RAM or stores to RAM.
  function automatic logic is_mem_op(input logic [7:0] ir_v);
    return (ir_v[2:0] == SRC_ROM) || (ir_v[2:0] == SRC_RAM) || (ir_v[6:4] == DST_RAM);
  endfunction

endpackage

// File: rtl/control_seq_wait_counter.sv
// Memory wait-state counter shared by the fetch and execute wait states.
module wait_counter #(
  parameter int MEM_WAIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic enable,
  output logic done
);

  localparam logic [3:0] LAST = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  logic [3:0] cnt_q, cnt_d;

  // Count is parked at zero outside a wait state and on the final wait cycle.
  always_comb begin
    done  = enable && (MEM_WAIT > 0) && (cnt_q == LAST);
    cnt_d = cnt_q + 4'd1;
    if (start || done || !enable) cnt_d = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/control_seq.sv
// Fetch/execute sequencer for nic8: instruction register, wait states, flags
// and one-hot register-load / bus-source strobes to the datapath.
module control_seq
  import control_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MEM_WAIT = 0
) (
  input  logic             clk,
  input  logic             resetBar,
  input  logic [7:0]       irIn,
  input  logic [WIDTH-1:0] a,
  input  logic             aluCarry,
  input  logic             aluShift,
  input  logic             run,
  output logic [7:0]       ir,
  output logic             loadIr,
  output logic             incPc,
  output logic [7:0]       load,
  output logic [7:0]       assertSrc,
  output logic             doSubtract,
  output logic             doCarryIn,
  output logic             doShiftIn,
  output logic             flagCarry,
  output logic             flagShift,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam bit HAS_WAIT = (MEM_WAIT > 0);

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       flag_carry_q, flag_carry_d;
  logic       flag_shift_q, flag_shift_d;

  logic       fetch_strobe, exec_strobe, in_exec;
  logic       wc_start, wc_en, wc_done;
  logic       cond_ok, jump;
  logic [2:0] src, dst;

  assign src = ir_q[2:0];
  assign dst = ir_q[6:4];

  wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk   (clk),
    .rst_n (resetBar),
    .start (wc_start),
    .enable(wc_en),
    .done  (wc_done)
  );

  always_comb begin
    cond_ok = 1'b1;
    case ({ir_q[7], ir_q[3]})
      COND_UNCOND: cond_ok = 1'b1;
      COND_ZERO:   cond_ok = (a == '0);
      COND_CARRY:  cond_ok = flag_carry_q;
      COND_SHIFT:  cond_ok = flag_shift_q;
      default:     cond_ok = 1'b1;
    endcase
    jump = (dst == DST_PC) && cond_ok;
  end

  // run acts as a request sampled only in idle FETCH; once accepted the
  // instruction always completes. Every strobe is valid for the whole cycle
  // and is consumed by the datapath on the rising edge that ends it.
  always_comb begin
    state_d      = state_q;
    fetch_strobe = 1'b0;
    exec_strobe  = 1'b0;
    in_exec      = 1'b0;
    wc_start     = 1'b0;
    wc_en        = 1'b0;
    case (state_q)
      FETCH: begin
        if (run) begin
          if (HAS_WAIT) begin
            state_d  = FETCH_WAIT;
            wc_start = 1'b1;
          end else begin
            fetch_strobe = 1'b1;
            state_d      = EXEC;
          end
        end
      end
      FETCH_WAIT: begin
        wc_en = 1'b1;
        if (wc_done) begin
          fetch_strobe = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        in_exec = 1'b1;
        if (HAS_WAIT && is_mem_op(ir_q)) begin
          state_d  = EXEC_WAIT;
          wc_start = 1'b1;
        end else begin
          exec_strobe = 1'b1;
          state_d     = FETCH;
        end
      end
      EXEC_WAIT: begin
        in_exec = 1'b1;
        wc_en   = 1'b1;
        if (wc_done) begin
          exec_strobe = 1'b1;
          state_d     = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    ir_d         = ir_q;
    flag_carry_d = flag_carry_q;
    flag_shift_d = flag_shift_q;
    if (fetch_strobe) ir_d = irIn;
    if (exec_strobe && src == SRC_E) flag_carry_d = aluCarry;
    if (exec_strobe && src == SRC_S) flag_shift_d = aluShift;

    loadIr    = 1'b0;
    incPc     = 1'b0;
    load      = 8'h00;
    assertSrc = 8'h00;
    if (resetBar) begin
      loadIr = fetch_strobe;
      incPc  = fetch_strobe || (exec_strobe && src == SRC_ROM && !jump);
      if (in_exec) assertSrc = 8'h01 << src;
      if (exec_strobe) begin
        if (dst >= DST_A && dst <= DST_Q) load[dst] = 1'b1;
        load[7] = jump;
      end
    end
    busy = resetBar && !(state_q == FETCH && !run);
  end

  always_ff @(posedge clk) begin
    if (!resetBar) begin
      state_q      <= FETCH;
      ir_q         <= 8'h00;
      flag_carry_q <= 1'b0;
      flag_shift_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      flag_carry_q <= flag_carry_d;
      flag_shift_q <= flag_shift_d;
    end
  end

  assign ir          = ir_q;
  assign flagCarry   = flag_carry_q;
  assign flagShift   = flag_shift_q;
  assign doSubtract  = ir_q[3];
  assign doCarryIn   = ir_q[7];
  assign doShiftIn   = ir_q[3];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: two instances (no waits, three waits) share stimulus
// and are compared every cycle against an instruction-position model.
module tb_control_seq;
  import control_pkg::*;

  localparam int W = 32;

  logic       clk = 1'b0;
  logic       resetBar = 1'b0;
  logic [7:0] irIn = 8'h00;
  logic [7:0] a = 8'h00;
  logic       aluCarry = 1'b0;
  logic       aluShift = 1'b0;
  logic       run = 1'b1;

  logic [7:0] ir_o[2];
  logic       loadIr_o[2];
  logic       incPc_o[2];
  logic [7:0] load_o[2];
  logic [7:0] assertSrc_o[2];
  logic       doSubtract_o[2];
  logic       doCarryIn_o[2];
  logic       doShiftIn_o[2];
  logic       flagCarry_o[2];
  logic       flagShift_o[2];
  logic       busy_o[2];
  logic [1:0] dbg_o[2];

  always #5 clk = ~clk;

  control_seq #(.WIDTH(8), .MEM_WAIT(0)) dut0 (
    .clk(clk), .resetBar(resetBar), .irIn(irIn), .a(a), .aluCarry(aluCarry),
    .aluShift(aluShift), .run(run), .ir(ir_o[0]), .loadIr(loadIr_o[0]),
    .incPc(incPc_o[0]), .load(load_o[0]), .assertSrc(assertSrc_o[0]),
    .doSubtract(doSubtract_o[0]), .doCarryIn(doCarryIn_o[0]), .doShiftIn(doShiftIn_o[0]),
    .flagCarry(flagCarry_o[0]), .flagShift(flagShift_o[0]), .busy(busy_o[0]),
    .dbg_state_o(dbg_o[0])
  );

  control_seq #(.WIDTH(8), .MEM_WAIT(3)) dut3 (
    .clk(clk), .resetBar(resetBar), .irIn(irIn), .a(a), .aluCarry(aluCarry),
    .aluShift(aluShift), .run(run), .ir(ir_o[1]), .loadIr(loadIr_o[1]),
    .incPc(incPc_o[1]), .load(load_o[1]), .assertSrc(assertSrc_o[1]),
    .doSubtract(doSubtract_o[1]), .doCarryIn(doCarryIn_o[1]), .doShiftIn(doShiftIn_o[1]),
    .flagCarry(flagCarry_o[1]), .flagShift(flagShift_o[1]), .busy(busy_o[1]),
    .dbg_state_o(dbg_o[1])
  );

  // Model: an instruction is a run of cycles counted from its start.
  int         mw_of[2] = '{0, 3};
  bit         m_active[2];
  int         m_pos[2];
  logic [7:0] m_ir[2];
  logic       m_fc[2];
  logic       m_fsh[2];
  bit         e_started[2];
  bit         e_fstb[2];
  bit         e_estb[2];
  int         e_pos[2];

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_v[2];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] observe(input int k);
    return {doShiftIn_o[k], doCarryIn_o[k], doSubtract_o[k], busy_o[k], flagShift_o[k],
            flagCarry_o[k], loadIr_o[k], incPc_o[k], load_o[k], assertSrc_o[k], ir_o[k]};
  endfunction

  task automatic model_expect(input int k);
    int pos, last, mw;
    logic [2:0] src, dst;
    logic mem, cond_ok, jump, lir, ipc, bsy;
    logic [7:0] ld, asrc;
    mw = mw_of[k];
    ld = 8'h00; asrc = 8'h00; lir = 1'b0; ipc = 1'b0; bsy = 1'b0;
    mem = 1'b0; cond_ok = 1'b0; jump = 1'b0; pos = 0; last = 0;
    e_started[k] = 0; e_fstb[k] = 0; e_estb[k] = 0;
    src = m_ir[k][2:0];
    dst = m_ir[k][6:4];
    if (resetBar && (m_active[k] || run)) begin
      e_started[k] = 1;
      bsy = 1'b1;
      pos = m_active[k] ? m_pos[k] : 0;
      if (pos == mw) begin
        lir = 1'b1; ipc = 1'b1; e_fstb[k] = 1;
      end else if (pos > mw) begin
        mem  = (src == 3'd1) || (src == 3'd5) || (dst == 3'd5);
        last = mw + ((mem && mw > 0) ? mw + 1 : 1);
        asrc = 8'h01 << src;
        if (pos == last) begin
          e_estb[k] = 1;
          case ({m_ir[k][7], m_ir[k][3]})
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = (a == 8'h00);
            2'b10:   cond_ok = m_fc[k];
            default: cond_ok = m_fsh[k];
          endcase
          jump = (dst == 3'd7) && cond_ok;
          if (dst >= 3'd2 && dst <= 3'd6) ld = 8'h01 << dst;
          if (jump) ld[7] = 1'b1;
          ipc = (src == 3'd1) && !jump;
        end
      end
    end
    e_pos[k] = pos;
    exp_q.push_back({m_ir[k][3], m_ir[k][7], m_ir[k][3], bsy, m_fsh[k], m_fc[k],
                     lir, ipc, ld, asrc, m_ir[k]});
  endtask

  task automatic model_update(input int k);
    if (!resetBar) begin
      m_active[k] = 0; m_pos[k] = 0; m_ir[k] = 8'h00; m_fc[k] = 1'b0; m_fsh[k] = 1'b0;
    end else if (e_started[k]) begin
      if (e_fstb[k]) m_ir[k] = irIn;
      if (e_estb[k]) begin
        if (m_ir[k][2:0] == 3'd6) m_fc[k] = aluCarry;
        if (m_ir[k][2:0] == 3'd7) m_fsh[k] = aluShift;
        m_active[k] = 0;
        m_pos[k] = 0;
      end else begin
        m_active[k] = 1;
        m_pos[k] = e_pos[k] + 1;
      end
    end
  endtask

  task automatic compare_vec(input int k, input logic [W-1:0] o, input logic [W-1:0] e);
    string p;
    p = (k == 0) ? "mw0" : "mw3";
    check({p, ".ir"}, 32'(o[7:0]), 32'(e[7:0]));
    check({p, ".assertSrc"}, 32'(o[15:8]), 32'(e[15:8]));
    check({p, ".load"}, 32'(o[23:16]), 32'(e[23:16]));
    check({p, ".loadIr_incPc"}, 32'(o[25:24]), 32'(e[25:24]));
    check({p, ".flags"}, 32'(o[27:26]), 32'(e[27:26]));
    check({p, ".busy"}, 32'(o[28]), 32'(e[28]));
    check({p, ".do_bits"}, 32'(o[31:29]), 32'(e[31:29]));
  endtask

  task automatic step();
    logic [W-1:0] e;
    @(negedge clk);
    model_expect(0);
    model_expect(1);
    for (int k = 0; k < 2; k++) begin
      obs_v[k] = observe(k);
      e = exp_q.pop_front();
      compare_vec(k, obs_v[k], e);
    end
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  initial begin
    int n_ld5, n_src4;
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_pos[k] = 0; m_ir[k] = 8'h00; m_fc[k] = 1'b0; m_fsh[k] = 1'b0;
    end

    // Reset held with run high.
    resetBar = 1'b0; run = 1'b1; irIn = 8'h21;
    repeat (3) step();
    check("rst_outputs", 32'(obs_v[0][28:0]), 32'd0);
    check("rst_state", 32'(dbg_o[0]), 32'(FETCH));

    // Immediate load A, no waits.
    resetBar = 1'b1;
    step();
    check("imm_loadIr", 32'(obs_v[0][25]), 32'd1);
    step();
    check("imm_src", 32'(obs_v[0][15:8]), 32'h02);
    check("imm_load", 32'(obs_v[0][23:16]), 32'h04);
    check("imm_incPc", 32'(obs_v[0][24]), 32'd1);

    // Jump on A zero, taken then not taken.
    irIn = 8'h79; a = 8'h00;
    step(); step();
    check("jz_load", 32'(obs_v[0][23:16]), 32'h80);
    check("jz_incPc", 32'(obs_v[0][24]), 32'd0);
    a = 8'h01;
    step(); step();
    check("jnz_load", 32'(obs_v[0][23:16]), 32'h00);
    check("jnz_incPc", 32'(obs_v[0][24]), 32'd1);

    // ALU to B sets carry, then jump on carry.
    irIn = 8'h36; aluCarry = 1'b1;
    step(); step();
    check("alu_load", 32'(obs_v[0][23:16]), 32'h08);
    irIn = 8'hF1; aluCarry = 1'b0;
    step();
    check("carry_flag", 32'(obs_v[0][26]), 32'd1);
    step();
    check("jc_load", 32'(obs_v[0][23:16]), 32'h80);
    check("jc_incPc", 32'(obs_v[0][24]), 32'd0);

    // RAM store with three wait states, then halt.
    resetBar = 1'b0;
    step();
    resetBar = 1'b1; irIn = 8'h52; a = 8'h5A;
    n_ld5 = 0; n_src4 = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (obs_v[1][21]) n_ld5++;
      if (obs_v[1][15:8] == 8'h04) n_src4++;
      if (i == 7) check("wait_ld5_last", 32'(obs_v[1][21]), 32'd1);
    end
    check("wait_ld5_pulses", n_ld5, 1);
    check("wait_src_cycles", n_src4, 4);
    run = 1'b0;
    step();
    check("halt_busy", 32'(obs_v[1][28]), 32'd0);
    step();
    check("halt_hold", 32'(obs_v[1][28:24]), 32'd0);

    // Reset during the execute wait abandons the store.
    run = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("midwait_src", 32'(obs_v[1][15:8]), 32'h04);
    resetBar = 1'b0;
    step();
    check("midrst_load", 32'(obs_v[1][23:16]), 32'h00);
    resetBar = 1'b1; run = 1'b0;
    step();
    check("midrst_busy", 32'(obs_v[1][28]), 32'd0);
    check("midrst_state", 32'(dbg_o[1]), 32'(FETCH));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      resetBar = ($urandom_range(0, 63) != 0);
      run      = ($urandom_range(0, 7) != 0);
      irIn     = 8'($urandom_range(0, 255));
      a        = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      aluCarry = 1'($urandom_range(0, 1));
      aluShift = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
